tx_word_arbiter: RTL and testbench

TX_WORD_ARBITER -- requirements
Module: tx_word_arbiter

---
 rtl/tx_word_arbiter.sv | 145 ++++++++++++++
 tb/tb_tx_word_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter
//   Round-robin arbiter that hands one 32-bit word at a time from three
//   requesters to the PC_TX serializer, then waits out the serializer's
//   busy handshake (busy rises, then falls) before granting again.
//
//   Optional build macro: TX_ARB_TIMEOUT_EN
//     When defined, a watchdog counts clocks spent in WAIT_BUSY/WAIT_DONE.
//     After TIMEOUT_CYCLES it forces the FSM back to IDLE and pulses
//     o_timeout. When undefined, no counter is built, o_timeout is tied
//     low and the wait states wait indefinitely.
//
// Ports
//   i_clock       rising-edge clock
//   i_reset_n     synchronous active-low reset
//   i_req_valid   per-requester "word pending", held until acked
//   i_reqN_word   requester N data, stable while its valid is high
//   o_req_ack     one-hot, one-cycle capture acknowledge
//   i_tx_busy     serializer busy flag
//   o_tx_word     registered word presented to the serializer
//   o_tx_start    one-cycle serialization start pulse
//   o_grant       index of the last granted requester
//   o_arb_idle    high while the FSM is in IDLE
//   o_timeout     one-cycle watchdog pulse (0 unless TX_ARB_TIMEOUT_EN)
module tx_word_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [2:0]  i_req_valid,
  input  logic [31:0] i_req0_word,
  input  logic [31:0] i_req1_word,
  input  logic [31:0] i_req2_word,
  output logic [2:0]  o_req_ack,
  input  logic        i_tx_busy,
  output logic [31:0] o_tx_word,
  output logic        o_tx_start,
  output logic [1:0]  o_grant,
  output logic        o_arb_idle,
  output logic        o_timeout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_hs;    // next state from the busy handshake alone
  logic [1:0]  state_next;  // handshake next state, overridden by watchdog
  logic        grant_now;
  logic [1:0]  pick;
  logic [31:0] pick_word;
  logic        wd_fire;

  // Round-robin search starting just after the last grant; the last
  // granted requester is checked last.
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = o_grant;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(o_grant) + i) % NUM_REQ;
      if (!found && i_req_valid[2'(idx)]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (pick)
      2'd0:    pick_word = i_req0_word;
      2'd1:    pick_word = i_req1_word;
      default: pick_word = i_req2_word;
    endcase
  end

  assign grant_now  = (state == IDLE) && (|i_req_valid) && !i_tx_busy;
  assign o_arb_idle = (state == IDLE);

  always_comb begin
    state_hs = state;
    case (state)
      IDLE:      if (grant_now)  state_hs = WAIT_BUSY;
      WAIT_BUSY: if (i_tx_busy)  state_hs = WAIT_DONE;
      WAIT_DONE: if (!i_tx_busy) state_hs = IDLE;
      default:                   state_hs = IDLE;
    endcase
  end

  assign state_next = wd_fire ? IDLE : state_hs;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_req_ack  <= '0;
      o_tx_start <= 1'b0;
      o_tx_word  <= '0;
      o_grant    <= 2'd2;
    end else begin
      state      <= state_next;
      o_req_ack  <= '0;
      o_tx_start <= 1'b0;
      if (grant_now) begin
        o_tx_word  <= pick_word;
        o_req_ack  <= 3'b001 << pick;
        o_tx_start <= 1'b1;
        o_grant    <= pick;
      end
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog;

  // Fires on the edge where the count would reach TIMEOUT_CYCLES, so the
  // pulse appears TIMEOUT_CYCLES clocks after entering a wait state.
  assign wd_fire = (state != IDLE) && (state_hs == state) &&
                   (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wdog      <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= wd_fire;
      if (wd_fire || (state_hs != state) || (state == IDLE)) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end
`else
  // The limit is only consumed when the watchdog is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_fire            = 1'b0;
  assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_tx_word_arbiter.sv
module tb_tx_word_arbiter;

  localparam logic [31:0] W0 = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'h12345678;
  localparam logic [31:0] W2 = 32'hCAFEF00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [31:0] word0, word1, word2;
  logic [2:0]  ack;
  logic        busy;
  logic [31:0] tx_word;
  logic        tx_start;
  logic [1:0]  grant;
  logic        idle;
  logic        timeout;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tx_word_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_req_valid (valid),
    .i_req0_word (word0),
    .i_req1_word (word1),
    .i_req2_word (word2),
    .o_req_ack   (ack),
    .i_tx_busy   (busy),
    .o_tx_word   (tx_word),
    .o_tx_start  (tx_start),
    .o_grant     (grant),
    .o_arb_idle  (idle),
    .o_timeout   (timeout)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  valid;
    logic        busy;
    logic [2:0]  ack;
    logic        start;
    logic [31:0] word;
    logic [1:0]  grant;
    logic        idle;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] v, input logic b,
                     input logic [2:0] a, input logic s, input logic [31:0] w,
                     input logic [1:0] g, input logic i);
    vec_t e;
    e.rst_n = r; e.valid = v; e.busy = b;
    e.ack = a; e.start = s; e.word = w; e.grant = g; e.idle = i;
    vecs.push_back(e);
  endtask

  function automatic logic [31:0] word_of(input int k);
    case (k)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          exp_order[3];
    logic [2:0]  pending;
    int          busy_cnt;
    int          n_ack;
    int          n_start;
    logic        exp_to;
    logic        exp_idle;

    rst_n = 1'b0; valid = '0; busy = 1'b0;
    word0 = W0; word1 = W1; word2 = W2;

    //   rst  valid  busy   ack    st  word  grant idle
    // single grant, busy 3 cycles, valid lingers through ack cycle
    add(0, 3'b000, 0,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b001, 0,  3'b001, 1, W0,    2'd0, 0);
    add(1, 3'b001, 1,  3'b000, 0, W0,    2'd0, 0);
    add(1, 3'b000, 1,  3'b000, 0, W0,    2'd0, 0);
    add(1, 3'b000, 1,  3'b000, 0, W0,    2'd0, 0);
    add(1, 3'b000, 0,  3'b000, 0, W0,    2'd0, 1);
    // busy high from reset while requester 1 waits
    add(0, 3'b010, 1,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b010, 1,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b010, 1,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b010, 0,  3'b010, 1, W1,    2'd1, 0);
    add(1, 3'b000, 1,  3'b000, 0, W1,    2'd1, 0);
    // reset while in WAIT_DONE, pending request regranted after busy drops
    add(1, 3'b100, 1,  3'b000, 0, W1,    2'd1, 0);
    add(0, 3'b100, 1,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b100, 1,  3'b000, 0, 32'h0, 2'd2, 1);
    add(1, 3'b100, 0,  3'b100, 1, W2,    2'd2, 0);
    add(1, 3'b000, 1,  3'b000, 0, W2,    2'd2, 0);
    // request 0 raised during WAIT_DONE waits for IDLE
    add(1, 3'b001, 1,  3'b000, 0, W2,    2'd2, 0);
    add(1, 3'b001, 0,  3'b000, 0, W2,    2'd2, 1);
    add(1, 3'b001, 0,  3'b001, 1, W0,    2'd0, 0);
    add(1, 3'b001, 0,  3'b000, 0, W0,    2'd0, 0);
    add(1, 3'b000, 1,  3'b000, 0, W0,    2'd0, 0);
    add(1, 3'b000, 0,  3'b000, 0, W0,    2'd0, 1);
    // simultaneous requests after grant 0: 1 wins, then 0
    add(1, 3'b011, 0,  3'b010, 1, W1,    2'd1, 0);
    add(1, 3'b011, 1,  3'b000, 0, W1,    2'd1, 0);
    add(1, 3'b001, 0,  3'b000, 0, W1,    2'd1, 1);
    add(1, 3'b001, 0,  3'b001, 1, W0,    2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; valid = vecs[i].valid; busy = vecs[i].busy;
      @(posedge clk); #1;
      tests++;
      if ({ack, tx_start, tx_word, grant, idle, timeout} !==
          {vecs[i].ack, vecs[i].start, vecs[i].word, vecs[i].grant, vecs[i].idle, 1'b0}) begin
        failed++;
        $display("FAIL vec%0d: ack=%b/%b start=%b/%b word=%h/%h grant=%0d/%0d idle=%b/%b timeout=%b/0 (actual/expected)",
                 i, ack, vecs[i].ack, tx_start, vecs[i].start, tx_word, vecs[i].word,
                 grant, vecs[i].grant, idle, vecs[i].idle, timeout);
      end
    end

    // Round robin with all three requesting, busy modelled 2 cycles high.
    exp_order = '{0, 1, 2};
    do_reset();
    pending = 3'b111; busy_cnt = 0; n_ack = 0; n_start = 0;
    valid = pending;
    for (int cyc = 0; cyc < 60 && !(pending == 0 && idle && busy_cnt == 0); cyc++) begin
      @(posedge clk); #1;
      if (tx_start) n_start++;
      if (ack != 3'b000) begin
        tests++;
        if (n_ack >= 3) begin
          failed++;
          $display("FAIL rr_extra_ack: ack=%b after %0d acks, required none", ack, n_ack);
        end else if (ack !== (3'b001 << exp_order[n_ack]) || !tx_start ||
                     tx_word !== word_of(exp_order[n_ack])) begin
          failed++;
          $display("FAIL rr_grant%0d: ack=%b start=%b word=%h, required ack=%b start=1 word=%h",
                   n_ack, ack, tx_start, tx_word, 3'b001 << exp_order[n_ack], word_of(exp_order[n_ack]));
        end
        pending = pending & ~ack;
        n_ack++;
      end
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) busy_cnt = 2;
      busy  = (busy_cnt != 0);
      valid = pending;
    end
    tests++;
    if (n_ack != 3 || n_start != 3 || pending != 3'b000) begin
      failed++;
      $display("FAIL rr_counts: acks=%0d starts=%0d pending=%b, required 3 3 000", n_ack, n_start, pending);
    end

    // Busy never rises after start: watchdog behaviour.
    do_reset();
    valid = 3'b001;
    @(posedge clk); #1;
    tests++;
    if (ack !== 3'b001 || !tx_start) begin
      failed++;
      $display("FAIL to_grant: ack=%b start=%b, required 001 1", ack, tx_start);
    end
    valid = 3'b000;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
`ifdef TX_ARB_TIMEOUT_EN
      exp_to   = (k == 16);
      exp_idle = (k >= 16);
`else
      exp_to   = 1'b0;
      exp_idle = 1'b0;
`endif
      tests++;
      if (timeout !== exp_to || idle !== exp_idle || ack !== 3'b000 || tx_start !== 1'b0) begin
        failed++;
        $display("FAIL to_cycle%0d: timeout=%b idle=%b ack=%b start=%b, required %b %b 000 0",
                 k, timeout, idle, ack, tx_start, exp_to, exp_idle);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
